// File: rtl/sd_clk_gen_if.sv
// SD clock generator control/status bundle.
// The master drives divider loads and stop requests.
// The slave (the generator) returns the clock phases, strobes and status.
interface sd_clk_gen_if #(
   parameter int DIV_WIDTH = 10
);
   logic [DIV_WIDTH-1:0] div_in;
   logic                 div_load;
   logic                 stop_req;
   logic                 stopped;
   logic                 sd_clk;
   logic [1:0]           sd_clk_ph;
   logic                 rise_stb;
   logic                 fall_stb;
   logic [DIV_WIDTH-1:0] div_active;
   logic                 load_pending;

   modport master (
      output div_in, div_load, stop_req,
      input  stopped, sd_clk, sd_clk_ph, rise_stb, fall_stb, div_active, load_pending
   );

   modport slave (
      input  div_in, div_load, stop_req,
      output stopped, sd_clk, sd_clk_ph, rise_stb, fall_stb, div_active, load_pending
   );
endinterface

// File: rtl/sd_clk_gen.sv
// SD card clock generator.
// A half-period counter toggles the next level (sd_clk_ph[1]) when it reaches
// div_active; sd_clk is that level registered once more, so strobes lead the edge.
// New divider values are only adopted at a high->low toggle or while parked, so a
// half is never cut short. A stop request parks the clock low after a complete low half.
module sd_clk_gen #(
   parameter int DIV_WIDTH = 10,
   parameter int INIT_DIV  = 249
) (
   input  logic         clk,
   input  logic         reset,
   sd_clk_gen_if.slave  bus
);

   localparam logic [DIV_WIDTH-1:0] INIT_DIV_V = DIV_WIDTH'(INIT_DIV);
   localparam logic [DIV_WIDTH-1:0] ONE_V      = DIV_WIDTH'(1);

   typedef enum logic {ST_RUN = 1'b0, ST_STOP = 1'b1} state_t;

   state_t               state_q, state_d;
   logic                 level_q, level_d;
   logic                 ph0_q;
   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
   logic [DIV_WIDTH-1:0] div_q, div_d;
   logic [DIV_WIDTH-1:0] pend_q, pend_d;
   logic                 pend_v_q, pend_v_d;
   logic                 term;
   logic                 apply;
   logic [DIV_WIDTH-1:0] new_div;
   logic                 has_new;

   // Next-state: half-period counting, stop parking and divider hand-over.
   always_comb begin
      term     = (cnt_q == div_q);
      // A load in the apply cycle itself wins over an older pending value.
      new_div  = bus.div_load ? bus.div_in : pend_q;
      has_new  = bus.div_load | pend_v_q;
      state_d  = state_q;
      level_d  = level_q;
      cnt_d    = cnt_q + ONE_V;
      div_d    = div_q;
      pend_d   = pend_q;
      pend_v_d = pend_v_q;
      apply    = 1'b0;

      if (state_q == ST_STOP) begin
         // Parked low: counter pinned at 0 so release yields a full low half.
         cnt_d   = '0;
         level_d = 1'b0;
         apply   = 1'b1;
         if (!bus.stop_req) begin
            state_d = ST_RUN;
         end
      end else if (term) begin
         cnt_d = '0;
         if (level_q) begin
            level_d = 1'b0;
            apply   = 1'b1;
         end else if (bus.stop_req) begin
            state_d = ST_STOP;
         end else begin
            level_d = 1'b1;
         end
      end

      if (apply && has_new) begin
         div_d    = new_div;
         pend_v_d = 1'b0;
      end else if (bus.div_load) begin
         pend_d   = bus.div_in;
         pend_v_d = 1'b1;
      end
   end

   // State register; reset parks everything low with the initial divider.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_RUN;
         level_q  <= 1'b0;
         ph0_q    <= 1'b0;
         cnt_q    <= '0;
         div_q    <= INIT_DIV_V;
         pend_q   <= '0;
         pend_v_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         level_q  <= level_d;
         ph0_q    <= level_q;
         cnt_q    <= cnt_d;
         div_q    <= div_d;
         pend_q   <= pend_d;
         pend_v_q <= pend_v_d;
      end
   end

   assign bus.sd_clk_ph    = {level_q, ph0_q};
   assign bus.sd_clk       = ph0_q;
   assign bus.rise_stb     = level_q & ~ph0_q;
   assign bus.fall_stb     = ~level_q & ph0_q;
   assign bus.div_active   = div_q;
   assign bus.load_pending = pend_v_q;
   assign bus.stopped      = (state_q == ST_STOP);

endmodule

// File: tb/tb_sd_clk_gen.sv
// Bench for sd_clk_gen with DIV_WIDTH=4, INIT_DIV=3.
// A countdown model of half-period lengths is compared every cycle, and directed
// scenarios pin literal cycle positions of edges, strobes and status.
module tb_sd_clk_gen;

   localparam int DW   = 4;
   localparam int INIT = 3;

   logic clk;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   sd_clk_gen_if #(.DIV_WIDTH(DW)) bus ();

   sd_clk_gen #(.DIV_WIDTH(DW), .INIT_DIV(INIT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   // Model: each half lasts div+1 edges; m_remain counts edges left in the half.
   initial begin : model_and_compare
      bit m_valid, m_level, m_ph0, m_park, m_pend_v, applied;
      bit s_rst, s_ld, s_sreq;
      int m_div, m_remain, m_pend, s_din, nd;
      m_valid = 0; m_level = 0; m_ph0 = 0; m_park = 0; m_pend_v = 0;
      m_div = INIT; m_remain = INIT + 1; m_pend = 0;
      forever begin
         @(posedge clk);
         s_rst  = reset;
         s_ld   = bus.div_load;
         s_sreq = bus.stop_req;
         s_din  = int'(bus.div_in);
         if (s_rst) begin
            m_valid = 1; m_level = 0; m_ph0 = 0; m_park = 0; m_pend_v = 0;
            m_div = INIT; m_remain = INIT + 1;
         end else begin
            m_ph0   = m_level;
            applied = 0;
            nd      = s_ld ? s_din : m_pend;
            if (m_park) begin
               if (s_ld || m_pend_v) begin
                  m_div = nd; m_pend_v = 0; applied = 1;
               end
               if (!s_sreq) m_park = 0;
               m_remain = m_div + 1;
            end else if (m_remain == 1) begin
               if (m_level) begin
                  m_level = 0;
                  if (s_ld || m_pend_v) begin
                     m_div = nd; m_pend_v = 0; applied = 1;
                  end
               end else if (s_sreq) begin
                  m_park = 1;
               end else begin
                  m_level = 1;
               end
               m_remain = m_div + 1;
            end else begin
               m_remain = m_remain - 1;
            end
            if (s_ld && !applied) begin
               m_pend = s_din; m_pend_v = 1;
            end
         end
         @(negedge clk);
         if (m_valid) begin
            chk("m_sd_clk_ph", {30'd0, bus.sd_clk_ph}, {30'd0, m_level, m_ph0});
            chk("m_sd_clk", {31'd0, bus.sd_clk}, {31'd0, m_ph0});
            chk("m_rise_stb", {31'd0, bus.rise_stb}, {31'd0, m_level & ~m_ph0});
            chk("m_fall_stb", {31'd0, bus.fall_stb}, {31'd0, ~m_level & m_ph0});
            chk("m_div_active", {28'd0, bus.div_active}, m_div);
            chk("m_load_pending", {31'd0, bus.load_pending}, {31'd0, m_pend_v});
            chk("m_stopped", {31'd0, bus.stopped}, {31'd0, m_park});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      cyc = cyc + 1;
      @(negedge clk);
   endtask

   // Directed scenarios; inputs change on the falling edge, cyc = rising edges since release.
   initial begin : directed
      reset = 1'b1; bus.div_in = '0; bus.div_load = 1'b0; bus.stop_req = 1'b0;
      repeat (3) step();
      chk("rst_sd_clk_ph", {30'd0, bus.sd_clk_ph}, 0);
      chk("rst_div_active", {28'd0, bus.div_active}, 3);
      chk("rst_load_pending", {31'd0, bus.load_pending}, 0);
      chk("rst_stopped", {31'd0, bus.stopped}, 0);
      chk("rst_rise_stb", {31'd0, bus.rise_stb}, 0);
      reset = 1'b0; cyc = 0;

      // Startup waveform: rise_stb at 4, high 5-8, low 9-12.
      for (int k = 1; k <= 12; k++) begin
         step();
         chk("A_rise_stb", {31'd0, bus.rise_stb}, (k == 4 || k == 12) ? 1 : 0);
         chk("A_sd_clk", {31'd0, bus.sd_clk}, (k >= 5 && k <= 8) ? 1 : 0);
         chk("A_fall_stb", {31'd0, bus.fall_stb}, (k == 8) ? 1 : 0);
      end

      // Load divider 0 mid-high-half.
      step(); chk("B_sd_clk13", {31'd0, bus.sd_clk}, 1);
      bus.div_load = 1'b1; bus.div_in = 4'd0;
      step(); bus.div_load = 1'b0;
      chk("B_pending14", {31'd0, bus.load_pending}, 1);
      step(); chk("B_pending15", {31'd0, bus.load_pending}, 1);
      chk("B_sd_clk15", {31'd0, bus.sd_clk}, 1);
      step(); chk("B_pending16", {31'd0, bus.load_pending}, 0);
      chk("B_div16", {28'd0, bus.div_active}, 0);
      chk("B_sd_clk16", {31'd0, bus.sd_clk}, 1);
      chk("B_fall16", {31'd0, bus.fall_stb}, 1);
      step(); chk("B_sd_clk17", {31'd0, bus.sd_clk}, 0);
      chk("B_rise17", {31'd0, bus.rise_stb}, 1);
      step(); chk("B_sd_clk18", {31'd0, bus.sd_clk}, 1);
      chk("B_fall18", {31'd0, bus.fall_stb}, 1);

      // Back to divider 3, then stop 1 cycle into a high half.
      bus.div_load = 1'b1; bus.div_in = 4'd3;
      step(); bus.div_load = 1'b0;
      chk("C_pending19", {31'd0, bus.load_pending}, 1);
      step(); chk("C_div20", {28'd0, bus.div_active}, 3);
      for (int k = 21; k <= 31; k++) begin
         step();
         if (k == 24) bus.stop_req = 1'b1;
         chk("C_sd_clk", {31'd0, bus.sd_clk}, (k >= 25 && k <= 28) ? 1 : 0);
         chk("C_stopped_low", {31'd0, bus.stopped}, 0);
      end
      for (int k = 32; k <= 51; k++) begin
         step();
         chk("C_stopped", {31'd0, bus.stopped}, 1);
         chk("C_held_low", {31'd0, bus.sd_clk_ph}, 0);
      end

      // Load 7 while stopped, then release.
      bus.div_load = 1'b1; bus.div_in = 4'd7;
      step(); bus.div_load = 1'b0;
      chk("D_div52", {28'd0, bus.div_active}, 7);
      chk("D_pending52", {31'd0, bus.load_pending}, 0);
      step(); bus.stop_req = 1'b0;
      step(); chk("D_stopped54", {31'd0, bus.stopped}, 0);
      for (int k = 55; k <= 62; k++) begin
         step();
         chk("D_rise_stb", {31'd0, bus.rise_stb}, (k == 62) ? 1 : 0);
         chk("D_sd_clk_low", {31'd0, bus.sd_clk}, 0);
      end
      step(); chk("D_sd_clk63", {31'd0, bus.sd_clk}, 1);

      // Back-to-back loads of 5 then 2 in one high half: only 2 lands.
      bus.div_load = 1'b1; bus.div_in = 4'd5;
      step(); bus.div_in = 4'd2;
      chk("E_pending64", {31'd0, bus.load_pending}, 1);
      step(); bus.div_load = 1'b0;
      for (int k = 66; k <= 69; k++) begin
         step();
         chk("E_pending", {31'd0, bus.load_pending}, 1);
         chk("E_div_old", {28'd0, bus.div_active}, 7);
      end
      step(); chk("E_div70", {28'd0, bus.div_active}, 2);
      chk("E_fall70", {31'd0, bus.fall_stb}, 1);
      for (int k = 71; k <= 73; k++) begin
         step();
         chk("E_rise_stb", {31'd0, bus.rise_stb}, (k == 73) ? 1 : 0);
      end

      // Load coinciding with the fall applies at once; then reset mid-high with div 9.
      step(); step();
      bus.div_load = 1'b1; bus.div_in = 4'd9;
      step(); bus.div_load = 1'b0;
      chk("F_div76", {28'd0, bus.div_active}, 9);
      chk("F_pending76", {31'd0, bus.load_pending}, 0);
      for (int k = 77; k <= 86; k++) begin
         step();
         chk("F_rise_stb", {31'd0, bus.rise_stb}, (k == 86) ? 1 : 0);
      end
      step(); step(); step();
      chk("F_sd_clk89", {31'd0, bus.sd_clk}, 1);
      reset = 1'b1;
      step(); reset = 1'b0;
      chk("F_sd_clk90", {31'd0, bus.sd_clk}, 0);
      chk("F_div90", {28'd0, bus.div_active}, 3);
      cyc = 0;
      for (int k = 1; k <= 5; k++) begin
         step();
         chk("F_rise_after_rst", {31'd0, bus.rise_stb}, (k == 4) ? 1 : 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
